camera_ray_gen: RTL and testbench
=================================

Name: camera_ray_gen

Overview:
- Sequential ray source for the intersection datapath. Produces the ray bundle that the intersection stage consumes.
- Walks every pixel of a WIDTH x HEIGHT frame in raster order and emits one primary ray per pixel.
- Ray format: origin = camera eye; direction = corner + x*du + y*dv, all Q16.16 signed.
- Rays leave on a valid/ready stream at up to one ray per cycle.
- The downstream shader/hit stage uses the emitted pixel coordinates to tag results.

Parameters:
- WIDTH, 640, pixels per row (>=1).
- HEIGHT, 480, rows per frame (>=1).
- XW, $clog2(WIDTH)+1, width of o_x.
- YW, $clog2(HEIGHT)+1, width of o_y.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- i_start, input, 1, frame start request; sampled only in IDLE.
- i_eye, input, [0:2][31:0] signed, camera origin in Q16.16.
- i_corner, input, [0:2][31:0] signed, direction for pixel (0,0).
- i_du, input, [0:2][31:0] signed, direction step per +1 x.
- i_dv, input, [0:2][31:0] signed, direction step per +1 y.
- o_ray, output, [0:1][0:2][31:0] signed, [0] is origin, [1] is direction; same layout as the intersection ray input.
- o_x, output, XW, pixel column of o_ray.
- o_y, output, YW, pixel row of o_ray.
- o_valid, output, 1, o_ray/o_x/o_y/o_last are valid.
- i_ready, input, 1, consumer accepts the current ray.
- o_last, output, 1, current ray is pixel (WIDTH-1, HEIGHT-1).
- o_busy, output, 1, a frame is in progress.
- o_done, output, 1, one-cycle pulse after the final ray is accepted.
- o_overflow, output, 1, sticky; a direction add overflowed during this frame.

Behaviour:
- Reset (synchronous): state=IDLE; o_valid, o_busy, o_done, o_last, o_overflow = 0; o_x, o_y, o_ray = 0.
- States: IDLE, RUN.
- IDLE:
  - i_start=1 latches i_eye, i_corner, i_du, i_dv into internal registers; later input changes have no effect on the frame.
  - Same edge: dir <= corner, row_base <= corner, x=y=0, o_overflow <= 0, state <= RUN.
  - Next cycle: o_valid=1, o_busy=1. Latency from start to first valid is 1 cycle.
- RUN:
  - o_valid stays 1. A handshake occurs when o_valid & i_ready.
  - Without a handshake, o_ray, o_x, o_y, o_last are held bit-stable.
  - i_start is ignored in RUN.
- Advance on handshake:
  - If x < WIDTH-1: dir <= dir + du; x <= x+1.
  - Else if y < HEIGHT-1: row_base <= row_base + dv; dir <= row_base + dv; x <= 0; y <= y+1.
  - Else (last pixel): o_valid <= 0, o_busy <= 0, o_done <= 1 for one cycle, state <= IDLE.
- o_last = (x==WIDTH-1) && (y==HEIGHT-1), registered alongside o_x/o_y.
- With i_ready held high, output is one ray per cycle with no bubbles, including across row wrap. A full frame takes WIDTH*HEIGHT cycles after the first valid.
- Arithmetic:
  - All adds are per-component 32-bit two's-complement; the result wraps.
  - Signed overflow (operand signs equal, result sign differs) on any component sets o_overflow.
  - o_overflow stays set until the next accepted i_start or reset.
  - No saturation. The origin is passed through unmodified (o_ray[0] = latched eye).
- Degenerate sizes:
  - WIDTH=1: every handshake takes the row-advance path.
  - WIDTH=HEIGHT=1: a single ray with o_last=1.
- Back-to-back frames: i_start asserted in the same cycle as o_done is accepted, since state is IDLE then; first valid follows 1 cycle later.
- Reset mid-frame: the frame is abandoned immediately. There is no o_done and o_valid=0 on the next cycle.

Test Plan:
- Basic raster, WIDTH=2 HEIGHT=2, i_ready=1.
  - Stimulus: eye=(0,0,0), corner=(0xFFFF0000,0x00010000,0xFFFF0000), du=(0x00008000,0,0), dv=(0,0xFFFF8000,0), start.
  - Required directions on consecutive cycles, with o_x/o_y (0,0),(1,0),(0,1),(1,1):
    - (0xFFFF0000,0x00010000,0xFFFF0000)
    - (0xFFFF8000,0x00010000,0xFFFF0000)
    - (0xFFFF0000,0x00008000,0xFFFF0000)
    - (0xFFFF8000,0x00008000,0xFFFF0000)
  - o_last=1 only on the 4th ray; o_done pulses exactly 1 cycle after the 4th handshake.
- Backpressure: same frame with i_ready toggling 1,0,0,1,0,1,1 -> each ray is held stable while not ready. Exactly 4 handshakes occur, with no duplicated or skipped pixels.
- Start and input changes while busy: pulse i_start and change i_corner mid-frame -> output sequence unchanged, and no second frame starts.
- Overflow: corner x=0x7FFF0000, du x=0x00020000, WIDTH=2 -> second ray x=0x80010000 (wrapped), o_overflow=1 and stays set until the next start.
- Reset mid-frame: assert reset after the 2nd handshake of a 4x4 frame -> next cycle o_valid=0, o_busy=0, o_overflow=0, no o_done. A new start then restarts at pixel (0,0).
- WIDTH=1, HEIGHT=3 with dv=(0,0x00010000,0) -> directions advance only in y: 0, 1.0, 2.0 offsets from corner. o_x stays 0 throughout, and o_last is asserted on ray 3.

Source files
------------

// File: rtl/camera_ray_gen.sv
// Raster-order primary ray source: one Q16.16 ray per pixel of a WIDTH x HEIGHT frame.
// Latency: first ray valid 1 cycle after an accepted i_start; then up to one ray per cycle.
// Backpressure: ray, coordinates and o_last hold bit-stable while o_valid && !i_ready.
module camera_ray_gen #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int XW     = $clog2(WIDTH) + 1,
   parameter int YW     = $clog2(HEIGHT) + 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             i_start,
   input  logic signed [0:2][31:0]          i_eye,
   input  logic signed [0:2][31:0]          i_corner,
   input  logic signed [0:2][31:0]          i_du,
   input  logic signed [0:2][31:0]          i_dv,
   output logic signed [0:1][0:2][31:0]     o_ray,
   output logic        [XW-1:0]             o_x,
   output logic        [YW-1:0]             o_y,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic                             o_last,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_overflow
);

   localparam logic [XW-1:0] X_MAX         = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX         = YW'(HEIGHT - 1);
   localparam logic          LAST_AT_START = (WIDTH == 1) && (HEIGHT == 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            done_nxt;

   // Frame parameters captured at start; dir is the ray being offered, row_base the x=0 ray of the row.
   logic [0:2][31:0] eye_q;
   logic [0:2][31:0] du_q;
   logic [0:2][31:0] dv_q;
   logic [0:2][31:0] dir_q;
   logic [0:2][31:0] row_base_q;

   logic [0:2][31:0] dir_step;
   logic [0:2][31:0] row_step;
   logic             step_ovf;
   logic             row_ovf;

   logic             hs;
   logic             row_end;
   logic             frame_end;
   logic [XW-1:0]    x_inc;
   logic [YW-1:0]    y_inc;

   assign hs        = (state == RUN) && i_ready;
   assign row_end   = (o_x == X_MAX);
   assign frame_end = row_end && (o_y == Y_MAX);
   assign x_inc     = o_x + XW'(1);
   assign y_inc     = o_y + YW'(1);

   assign o_valid   = (state == RUN);
   assign o_busy    = (state == RUN);
   assign o_ray     = {eye_q, dir_q};

   // Both candidate next directions with per-component signed-overflow detection.
   always_comb begin
      dir_step = '0;
      row_step = '0;
      step_ovf = 1'b0;
      row_ovf  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         dir_step[c] = dir_q[c] + du_q[c];
         row_step[c] = row_base_q[c] + dv_q[c];
         step_ovf = step_ovf | ((dir_q[c][31] == du_q[c][31]) && (dir_step[c][31] != dir_q[c][31]));
         row_ovf  = row_ovf  | ((row_base_q[c][31] == dv_q[c][31]) && (row_step[c][31] != row_base_q[c][31]));
      end
   end

   // State register and the one-cycle done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         o_done <= 1'b0;
      end else begin
         state  <= state_nxt;
         o_done <= done_nxt;
      end
   end

   // Next state: start leaves IDLE, acceptance of the final pixel returns to IDLE.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (hs && frame_end) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture on start, then step along the row or wrap to the next row on each handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         eye_q      <= '0;
         du_q       <= '0;
         dv_q       <= '0;
         dir_q      <= '0;
         row_base_q <= '0;
         o_x        <= '0;
         o_y        <= '0;
         o_last     <= 1'b0;
         o_overflow <= 1'b0;
      end else if ((state == IDLE) && i_start) begin
         eye_q      <= i_eye;
         du_q       <= i_du;
         dv_q       <= i_dv;
         dir_q      <= i_corner;
         row_base_q <= i_corner;
         o_x        <= '0;
         o_y        <= '0;
         o_last     <= LAST_AT_START;
         o_overflow <= 1'b0;
      end else if (hs && !frame_end) begin
         if (!row_end) begin
            dir_q      <= dir_step;
            o_x        <= x_inc;
            o_last     <= (x_inc == X_MAX) && (o_y == Y_MAX);
            o_overflow <= o_overflow | step_ovf;
         end else begin
            row_base_q <= row_step;
            dir_q      <= row_step;
            o_x        <= '0;
            o_y        <= y_inc;
            o_last     <= (X_MAX == '0) && (y_inc == Y_MAX);
            o_overflow <= o_overflow | row_ovf;
         end
      end
   end

endmodule

// File: tb/tb_camera_ray_gen.sv
// Bench for camera_ray_gen: three instances (2x2, 4x4, 1x3) driven by directed and random frames.
// Expected rays come from direction = corner + x*du + y*dv, overflow from exact 64-bit sums.
// Ready patterns: always-on, fixed toggle pattern, and random.
module tb_camera_ray_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [2:0]                          rst;
   logic [2:0]                          start;
   logic [2:0]                          ready;
   logic [0:2][31:0]                    eye    [3];
   logic [0:2][31:0]                    corner [3];
   logic [0:2][31:0]                    du     [3];
   logic [0:2][31:0]                    dv     [3];
   logic signed [0:1][0:2][31:0]        ray    [3];
   logic [2:0]                          valid;
   logic [2:0]                          last;
   logic [2:0]                          busy;
   logic [2:0]                          done;
   logic [2:0]                          ovf;
   logic [1:0]                          x0, y0;
   logic [2:0]                          x1, y1;
   logic [0:0]                          x2;
   logic [2:0]                          y2;
   logic [31:0]                         ox [3];
   logic [31:0]                         oy [3];

   assign ox[0] = 32'(x0);
   assign oy[0] = 32'(y0);
   assign ox[1] = 32'(x1);
   assign oy[1] = 32'(y1);
   assign ox[2] = 32'(x2);
   assign oy[2] = 32'(y2);

   camera_ray_gen #(.WIDTH(2), .HEIGHT(2)) u_a (
      .clk(clk), .reset(rst[0]), .i_start(start[0]),
      .i_eye(eye[0]), .i_corner(corner[0]), .i_du(du[0]), .i_dv(dv[0]),
      .o_ray(ray[0]), .o_x(x0), .o_y(y0), .o_valid(valid[0]), .i_ready(ready[0]),
      .o_last(last[0]), .o_busy(busy[0]), .o_done(done[0]), .o_overflow(ovf[0])
   );

   camera_ray_gen #(.WIDTH(4), .HEIGHT(4)) u_b (
      .clk(clk), .reset(rst[1]), .i_start(start[1]),
      .i_eye(eye[1]), .i_corner(corner[1]), .i_du(du[1]), .i_dv(dv[1]),
      .o_ray(ray[1]), .o_x(x1), .o_y(y1), .o_valid(valid[1]), .i_ready(ready[1]),
      .o_last(last[1]), .o_busy(busy[1]), .o_done(done[1]), .o_overflow(ovf[1])
   );

   camera_ray_gen #(.WIDTH(1), .HEIGHT(3)) u_c (
      .clk(clk), .reset(rst[2]), .i_start(start[2]),
      .i_eye(eye[2]), .i_corner(corner[2]), .i_du(du[2]), .i_dv(dv[2]),
      .o_ray(ray[2]), .o_x(x2), .o_y(y2), .o_valid(valid[2]), .i_ready(ready[2]),
      .o_last(last[2]), .o_busy(busy[2]), .o_done(done[2]), .o_overflow(ovf[2])
   );

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference direction of pixel (x,y), modulo 2^32 per component.
   function automatic logic [0:2][31:0] mdir(input logic [0:2][31:0] c, u, v, input int x, y);
      logic [0:2][31:0] r;
      for (int i = 0; i < 3; i++) r[i] = c[i] + u[i] * 32'(x) + v[i] * 32'(y);
      return r;
   endfunction

   // True when the exact sum of any component pair leaves the int32 range.
   function automatic bit add_ovf(input logic [0:2][31:0] a, b);
      longint s;
      bit o;
      o = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s = longint'($signed(a[i])) + longint'($signed(b[i]));
         if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1'b1;
      end
      return o;
   endfunction

   task automatic launch(input int k, input logic [0:2][31:0] e, c, u, v, input bit imm);
      if (!imm) begin
         @(negedge clk);
         chk("idle_done", 192'(done[k]), 192'(0));
         chk("idle_valid", 192'(valid[k]), 192'(0));
      end
      eye[k] = e; corner[k] = c; du[k] = u; dv[k] = v;
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic run_frame(input int k, w, h, input logic [0:2][31:0] e, c, u, v,
                            input int mode, input int nstop, input bit mid_change);
      int  n, cyc, x, y, target;
      bit  ov, rdy, changed;
      logic [0:2][31:0] exp_dir;
      int  pat [7] = '{1, 0, 0, 1, 0, 1, 1};
      target  = (nstop > 0) ? nstop : w * h;
      n = 0; cyc = 0; ov = 1'b0; changed = 1'b0;
      while (n < target && cyc < 1000) begin
         x = n % w;
         y = n / w;
         exp_dir = mdir(c, u, v, x, y);
         chk("valid", 192'(valid[k]), 192'(1));
         chk("busy", 192'(busy[k]), 192'(1));
         chk("done_mid", 192'(done[k]), 192'(0));
         chk("x", 192'(ox[k]), 192'(x));
         chk("y", 192'(oy[k]), 192'(y));
         chk("last", 192'(last[k]), 192'(n == w * h - 1));
         chk("overflow", 192'(ovf[k]), 192'(ov));
         chk("origin", 192'(ray[k][0]), 192'(e));
         for (int i = 0; i < 3; i++)
            chk($sformatf("dir%0d", i), 192'(ray[k][1][i]), 192'(exp_dir[i]));
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = pat[cyc % 7] != 0;
            default: rdy = $urandom_range(0, 1) != 0;
         endcase
         ready[k] = rdy;
         if (mid_change && n == 1 && !changed) begin
            start[k] = 1'b1;
            corner[k] = {$urandom, $urandom, $urandom};
            eye[k] = {$urandom, $urandom, $urandom};
            du[k] = {$urandom, $urandom, $urandom};
            changed = 1'b1;
         end else begin
            start[k] = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (rdy) begin
            if (n < w * h - 1) begin
               if (x < w - 1) ov = ov | add_ovf(exp_dir, u);
               else           ov = ov | add_ovf(mdir(c, u, v, 0, y), v);
            end
            n++;
         end
      end
      start[k] = 1'b0;
      chk("handshakes", 192'(n), 192'(target));
      if (nstop == 0) begin
         chk("done_pulse", 192'(done[k]), 192'(1));
         chk("end_valid", 192'(valid[k]), 192'(0));
         chk("end_busy", 192'(busy[k]), 192'(0));
         chk("end_overflow", 192'(ovf[k]), 192'(ov));
      end
   endtask

   logic [0:2][31:0] e, c, u, v, zero3;

   initial begin
      zero3 = '0;
      rst = 3'b111; start = '0; ready = 3'b111;
      for (int k = 0; k < 3; k++) begin
         eye[k] = '0; corner[k] = '0; du[k] = '0; dv[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_valid", 192'(valid[k]), 192'(0));
         chk("rst_busy", 192'(busy[k]), 192'(0));
         chk("rst_done", 192'(done[k]), 192'(0));
         chk("rst_last", 192'(last[k]), 192'(0));
         chk("rst_overflow", 192'(ovf[k]), 192'(0));
         chk("rst_x", 192'(ox[k]), 192'(0));
         chk("rst_y", 192'(oy[k]), 192'(0));
         chk("rst_ray", 192'(ray[k]), 192'(0));
      end
      rst = '0;

      // Basic 2x2 raster.
      c = {32'hFFFF0000, 32'h00010000, 32'hFFFF0000};
      u = {32'h00008000, 32'h0, 32'h0};
      v = {32'h0, 32'hFFFF8000, 32'h0};
      launch(0, zero3, c, u, v, 1'b0);
      run_frame(0, 2, 2, zero3, c, u, v, 0, 0, 1'b0);

      // Same frame under the 1,0,0,1,0,1,1 ready pattern.
      e = {$urandom, $urandom, $urandom};
      launch(0, e, c, u, v, 1'b0);
      run_frame(0, 2, 2, e, c, u, v, 1, 0, 1'b0);

      // Start pulse and input changes mid-frame must not disturb the frame.
      launch(0, e, c, u, v, 1'b0);
      run_frame(0, 2, 2, e, c, u, v, 0, 0, 1'b1);
      @(negedge clk);
      chk("no_restart", 192'(valid[0]), 192'(0));

      // Overflow in x, then back-to-back start on the done cycle.
      c = {32'h7FFF0000, 32'h0, 32'h0};
      u = {32'h00020000, 32'h0, 32'h0};
      v = {32'h0, 32'h00010000, 32'h0};
      launch(0, zero3, c, u, v, 1'b0);
      run_frame(0, 2, 2, zero3, c, u, v, 0, 0, 1'b0);
      chk("ovf_wrap_value", 192'(ray[0][1][0]), 192'(32'h80010000));
      chk("ovf_sticky_idle", 192'(ovf[0]), 192'(1));
      c = {32'h00010000, 32'h00020000, 32'h00030000};
      launch(0, e, c, u, v, 1'b1);
      run_frame(0, 2, 2, e, c, u, v, 2, 0, 1'b0);

      // Random 4x4 frames: full-range operands, then small ones.
      for (int r = 0; r < 4; r++) begin
         e = {$urandom, $urandom, $urandom};
         if (r < 2) begin
            c = {$urandom, $urandom, $urandom};
            u = {$urandom, $urandom, $urandom};
            v = {$urandom, $urandom, $urandom};
         end else begin
            c = {32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)), 32'h0};
            u = {32'($urandom_range(0, 4095)), 32'h0, 32'hFFFFF000};
            v = {32'h0, 32'($urandom_range(0, 4095)), 32'h00001000};
         end
         launch(1, e, c, u, v, 1'b0);
         run_frame(1, 4, 4, e, c, u, v, 2, 0, 1'b0);
      end

      // Reset after the second handshake of an overflowing 4x4 frame.
      c = {32'h7FFF0000, 32'h0, 32'h0};
      u = {32'h00020000, 32'h0, 32'h0};
      v = {32'h0, 32'h00010000, 32'h0};
      launch(1, zero3, c, u, v, 1'b0);
      run_frame(1, 4, 4, zero3, c, u, v, 0, 2, 1'b0);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      chk("mid_rst_valid", 192'(valid[1]), 192'(0));
      chk("mid_rst_busy", 192'(busy[1]), 192'(0));
      chk("mid_rst_overflow", 192'(ovf[1]), 192'(0));
      chk("mid_rst_done", 192'(done[1]), 192'(0));
      c = {32'h00010000, 32'h0, 32'hFFFF0000};
      launch(1, e, c, u, v, 1'b0);
      run_frame(1, 4, 4, e, c, u, v, 0, 0, 1'b0);

      // Single-column frame: only the row-advance path.
      c = {32'h00001000, 32'h00002000, 32'h00003000};
      u = {32'h00005000, 32'h00005000, 32'h00005000};
      v = {32'h0, 32'h00010000, 32'h0};
      launch(2, e, c, u, v, 1'b0);
      run_frame(2, 1, 3, e, c, u, v, 0, 0, 1'b0);
      launch(2, e, c, u, v, 1'b0);
      run_frame(2, 1, 3, e, c, u, v, 2, 0, 1'b0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
